interrupt_controller: RTL

Upstream companion to the pipelined processor. Collects asynchronous interrupt requests from several peripheral sources, synchronizes and edge-detects them, holds them pending under a software mask, and drives the processor's single `interrupt_signal` input as a fixed-length pulse. It then blocks further interrupts until the processor reports that the interrupt service routine has returned (RTI retired). It also reports the granted source index, which the fetch/decode path uses for vector selection.

---
 rtl/interrupt_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: per-source synchronizers and edge detectors, a masked
// pending register, and a fixed-length interrupt pulse held off until RTI retires.
module interrupt_controller #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 2,
  parameter int ID_W        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               rti_done,
  output logic               interrupt_signal,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
  logic [NUM_SRC-1:0] edge_r;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] grant_oh_s;
  logic [NUM_SRC-1:0] clr_s;
  logic               grant_any_s;
  logic [ID_W-1:0]    grant_idx_s;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               int_r, int_nxt_s;
  logic [ID_W-1:0]    id_r, id_nxt_s;
  logic               insvc_r, insvc_nxt_s;

  // Input synchronizer chain plus the delay flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
      edge_r <= '0;
    end else begin
      sync_r[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      edge_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise_s = sync_r[SYNC_STAGES-1] & ~edge_r;

  // Fixed priority select: lowest eligible index wins
  always_comb begin
    eligible_s  = pending_r & ~mask_r;
    grant_any_s = |eligible_s;
    grant_idx_s = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      grant_idx_s = eligible_s[i] ? ID_W'(i) : grant_idx_s;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_oh_s[i] = grant_any_s && (grant_idx_s == ID_W'(i));
    end
  end

  // FSM next-state and next register values
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    int_nxt_s   = int_r;
    id_nxt_s    = id_r;
    insvc_nxt_s = insvc_r;
    clr_s       = '0;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_nxt_s = ST_ASSERT;
          cnt_nxt_s   = CNT_W'(PULSE_LEN - 1);
          int_nxt_s   = 1'b1;
          id_nxt_s    = grant_idx_s;
          insvc_nxt_s = 1'b1;
          clr_s       = grant_oh_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (cnt_r == '0) begin
          state_nxt_s = ST_SERVICE;
          int_nxt_s   = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_SERVICE: begin
        if (rti_done) begin
          state_nxt_s = ST_IDLE;
          insvc_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
        int_nxt_s   = 1'b0;
        insvc_nxt_s = 1'b0;
      end
    endcase
  end

  // State, output and pending/mask registers; a same-cycle edge beats the grant clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      int_r     <= 1'b0;
      id_r      <= '0;
      insvc_r   <= 1'b0;
      pending_r <= '0;
      mask_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      int_r     <= int_nxt_s;
      id_r      <= id_nxt_s;
      insvc_r   <= insvc_nxt_s;
      pending_r <= (pending_r & ~clr_s) | rise_s;
      mask_r    <= mask_we ? mask_wdata : mask_r;
    end
  end

  assign interrupt_signal = int_r;
  assign irq_id           = id_r;
  assign in_service       = insvc_r;
  assign pending          = pending_r;
  assign mask             = mask_r;

endmodule
